h_mux4_way16: RTL and testbench
===============================

H_MUX4_WAY16 -- requirements
Module: h_mux4_way16

Interface
REQ-001 Parameter WIDTH, default 16, data width of every data input and of out.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  data selected when sel=2'b00.
REQ-005 b  input  WIDTH  data selected when sel=2'b01.
REQ-006 c  input  WIDTH  data selected when sel=2'b10.
REQ-007 d  input  WIDTH  data selected when sel=2'b11.
REQ-008 sel  input  2  select code.
REQ-009 in_valid  input  1  qualifies a/b/c/d/sel for capture.
REQ-010 out  output  WIDTH  selected data.
REQ-011 out_valid  output  1  out carries a selection made from a valid input.
REQ-012 out_sel  output  2  sel value that produced the current out.

Function
REQ-013 Selection SHALL be a=00, b=01, c=10, d=11; all four codes are legal, and no default or X branch is reachable.
REQ-014 Selection SHALL pass all WIDTH bits unmodified, with no sign extension, truncation or arithmetic.
REQ-015 Registered mode: on a rising clk with in_valid=1, out, out_sel and out_valid SHALL load the selected word, sel and 1, giving one-cycle latency.
REQ-016 Registered mode: on a rising clk with in_valid=0, out and out_sel SHALL hold and out_valid SHALL load 0.
REQ-017 Registered mode: a change on sel or any data input between edges SHALL NOT affect out until the next qualifying edge.
REQ-018 Combinational mode: out SHALL equal the selected input, out_sel SHALL equal sel and out_valid SHALL equal in_valid, all with zero latency and independent of clk.
REQ-019 Back-to-back valid cycles with different sel SHALL produce a new selection on every cycle, with no bubble.

Reset
REQ-020 While rst_n=0, out SHALL be all zeros, out_sel SHALL be 2'b00 and out_valid SHALL be 0, applied immediately and not waiting for clk.
REQ-021 Reset asserted in the middle of a valid stream SHALL discard the pending selection; the first output after release SHALL come from the first valid edge after release.
REQ-022 In combinational mode rst_n SHALL gate only out_valid to 0; out and out_sel SHALL still follow the inputs.

Configuration
REQ-023 Macro H_MUX4_WAY16_REG_OUT_EN defined SHALL select registered mode (REQ-015..017, REQ-020, REQ-021).
REQ-024 With the macro undefined, the module SHALL build in combinational mode (REQ-018, REQ-022), contain no flip-flops and keep the same port list.

Structure
REQ-025 The shared package SHALL hold the WIDTH default constant (16), the 2-bit select typedef, and the named select constants SEL_A=0, SEL_B=1, SEL_C=2, SEL_D=3.
REQ-026 The combinational 4:1 selection SHALL live in one sub-module, h_mux4_core, parameterised by WIDTH; the top SHALL add only the optional register stage and reset gating.

Verification
REQ-027 Reset: hold rst_n=0 with a=16'hFFFF and sel=00 -> out=16'h0000, out_valid=0 (registered build).
REQ-028 Sweep: a=0, b=1, c=2, d=3, in_valid=1, sel 00,01,10,11 on successive cycles -> out 0,1,2,3 each one cycle later (registered) or immediately (combinational), with out_sel matching sel.
REQ-029 Full-width check: a=16'hA5A5, d=16'h5A5A, sel toggling 00 and 11 -> out alternates 16'hA5A5 and 16'h5A5A with every bit intact.
REQ-030 Hold: after out=16'h0003 with sel=11, drive in_valid=0, sel=00, d=16'h7777 -> out stays 16'h0003, out_valid=0.
REQ-031 Mid-stream reset: pulse rst_n low for half a cycle during a valid stream -> out=0 and out_valid=0 at once, then the correct value on the first valid edge after release.

Source files
------------

// File: rtl/h_mux4_way16_pkg.sv
// Shared definitions for the h_mux4_way16 4:1 word multiplexer.
package h_mux4_way16_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'd0;
    localparam sel_t SEL_B = 2'd1;
    localparam sel_t SEL_C = 2'd2;
    localparam sel_t SEL_D = 2'd3;

endpackage

// File: rtl/h_mux4_way16_if.sv
// Bus bundle for h_mux4_way16: four data words, select and valid in,
// selected word, select echo and valid out.
interface h_mux4_way16_if
    import h_mux4_way16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    sel_t             sel;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    sel_t             out_sel;

    modport master (
        output a, b, c, d, sel, in_valid,
        input  out, out_valid, out_sel
    );

    modport slave (
        input  a, b, c, d, sel, in_valid,
        output out, out_valid, out_sel
    );

endinterface

// File: rtl/h_mux4_way16_core.sv
// Pure combinational 4:1 word selector shared by both build modes.
module h_mux4_core
    import h_mux4_way16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  sel_t             sel_i,
    output logic [WIDTH-1:0] y_o
);

    // Every 2-bit code maps to one input; the word passes through untouched.
    always_comb begin
        y_o = a_i;
        case (sel_i)
            SEL_A: y_o = a_i;
            SEL_B: y_o = b_i;
            SEL_C: y_o = c_i;
            SEL_D: y_o = d_i;
        endcase
    end

endmodule

// File: rtl/h_mux4_way16.sv
// h_mux4_way16: 4:1 WIDTH-bit multiplexer with optional output register.
// Build option: define H_MUX4_WAY16_REG_OUT_EN for the registered
// (one-cycle latency) variant; otherwise the block is purely combinational
// and rst_n only forces out_valid low.
module h_mux4_way16
    import h_mux4_way16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input logic          clk,
    input logic          rst_n,
    h_mux4_way16_if.slave bus
);

    logic [WIDTH-1:0] sel_word;

    h_mux4_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a_i   (bus.a),
        .b_i   (bus.b),
        .c_i   (bus.c),
        .d_i   (bus.d),
        .sel_i (bus.sel),
        .y_o   (sel_word)
    );

`ifdef H_MUX4_WAY16_REG_OUT_EN

    logic [WIDTH-1:0] out_q, out_d;
    sel_t             sel_q, sel_d;
    logic             valid_q, valid_d;

    // Load a new selection on a valid cycle; otherwise hold data, drop valid.
    always_comb begin
        out_d   = out_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            out_d   = sel_word;
            sel_d   = bus.sel;
            valid_d = 1'b1;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            sel_q   <= SEL_A;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

`else

    // Clock is part of the port list only so both builds stay drop-in.
    logic unused_clk;
    assign unused_clk = clk;

    assign bus.out       = sel_word;
    assign bus.out_sel   = bus.sel;
    assign bus.out_valid = bus.in_valid & rst_n;

`endif

endmodule

// File: tb/tb_h_mux4_way16.sv
// Self-checking bench for h_mux4_way16; follows the build macro
// H_MUX4_WAY16_REG_OUT_EN to pick registered or combinational expectations.
module tb_h_mux4_way16;

    typedef struct {
        logic [15:0] out;
        logic [1:0]  sel;
        logic        valid;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Reference state of the output register (registered build).
    logic [15:0] m_out   = '0;
    logic [1:0]  m_sel   = '0;
    logic        m_valid = 1'b0;

    h_mux4_way16_if #(.WIDTH(16)) bus ();

    h_mux4_way16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] pick(input logic [15:0] av, bv, cv, dv,
                                         input logic [1:0] s);
        if (s == 2'b00) return av;
        else if (s == 2'b01) return bv;
        else if (s == 2'b10) return cv;
        else return dv;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] o, input logic [1:0] s,
                           input logic v);
        exp_t e;
        e.out   = o;
        e.sel   = s;
        e.valid = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        check({tag, "_depth"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_out"}, bus.out, e.out);
            check({tag, "_sel"}, bus.out_sel, e.sel);
            check({tag, "_valid"}, bus.out_valid, e.valid);
        end
    endtask

    task automatic model_reset();
        m_out   = '0;
        m_sel   = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        if (bus.in_valid) begin
            m_out   = pick(bus.a, bus.b, bus.c, bus.d, bus.sel);
            m_sel   = bus.sel;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and check the response.
    task automatic step(input string tag, input logic [15:0] av, bv, cv, dv,
                        input logic [1:0] s, input logic v);
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.c = cv;
        bus.d = dv;
        bus.sel = s;
        bus.in_valid = v;
        #1;
`ifdef H_MUX4_WAY16_REG_OUT_EN
        sb_push(m_out, m_sel, m_valid);
        sb_check({tag, "_mid"});
        model_edge();
        sb_push(m_out, m_sel, m_valid);
        @(posedge clk);
        #1;
        sb_check(tag);
`else
        sb_push(pick(av, bv, cv, dv, s), s, v & rst_n);
        sb_check(tag);
`endif
    endtask

    task automatic expect_now(input string tag);
`ifdef H_MUX4_WAY16_REG_OUT_EN
        sb_push(m_out, m_sel, m_valid);
`else
        sb_push(pick(bus.a, bus.b, bus.c, bus.d, bus.sel), bus.sel,
                bus.in_valid & rst_n);
`endif
        sb_check(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.a = 16'hFFFF;
        bus.b = 16'h0000;
        bus.c = 16'h0000;
        bus.d = 16'h0000;
        bus.sel = 2'b00;
        bus.in_valid = 1'b1;

        // Reset applied before any clock edge must act immediately.
        #2 rst_n = 1'b0;
        model_reset();
        #1 expect_now("reset");
        repeat (2) @(posedge clk);
        #1 expect_now("reset_held");

        @(negedge clk);
        rst_n = 1'b1;

        // Sweep all four codes back to back.
        for (int i = 0; i < 4; i++)
            step("sweep", 16'd0, 16'd1, 16'd2, 16'd3, 2'(i), 1'b1);

        // Full-width patterns alternating between a and d.
        for (int i = 0; i < 4; i++)
            step("width", 16'hA5A5, 16'h1234, 16'hFEDC, 16'h5A5A,
                 (i % 2 == 0) ? 2'b00 : 2'b11, 1'b1);

        // Hold: load 3 via d, then an invalid cycle with new sel and data.
        step("load3", 16'd0, 16'd1, 16'd2, 16'd3, 2'b11, 1'b1);
        step("hold", 16'hA5A5, 16'd1, 16'd2, 16'h7777, 2'b00, 1'b0);
        step("hold2", 16'hC3C3, 16'd9, 16'd8, 16'h7777, 2'b10, 1'b0);

        // Random back-to-back traffic.
        for (int i = 0; i < 12; i++)
            step("rand", 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));

        // Mid-stream reset: half-cycle low pulse during valid traffic.
        step("pre_rst", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b10, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 expect_now("mid_rst");
        #4 rst_n = 1'b1;
        #1 expect_now("rel");
`ifdef H_MUX4_WAY16_REG_OUT_EN
        model_edge();
        @(posedge clk);
        #1 expect_now("post_rst");
`endif
        step("after_rst", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b01, 1'b1);
        step("after_rst2", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b11, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
